// File: rtl/elastic_rr_arbiter.sv
// Round-robin arbiter with packet locking that merges num_req_p valid/ready
// streams into one registered elastic output stage (one beat per cycle).
module elastic_rr_arbiter #(
  parameter int width_p   = 8,
  parameter int num_req_p = 4,
  parameter int id_w_p    = $clog2(num_req_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic [num_req_p*width_p-1:0] data_i,
  input  logic [num_req_p-1:0]         valid_i,
  input  logic [num_req_p-1:0]         last_i,
  output logic [num_req_p-1:0]         ready_o,
  output logic                         valid_o,
  output logic [width_p-1:0]           data_o,
  output logic                         last_o,
  output logic [id_w_p-1:0]            id_o,
  input  logic                         ready_i
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [id_w_p-1:0]   ptr_q, ptr_d;
  logic [id_w_p-1:0]   owner_q, owner_d;
  logic                valid_q, valid_d;
  logic [width_p-1:0]  data_q, data_d;
  logic                last_q, last_d;
  logic [id_w_p-1:0]   id_q, id_d;

  logic                stage_ready;
  logic                gnt_vld;
  logic [id_w_p-1:0]   gnt;
  logic [id_w_p-1:0]   cand;
  int                  scan_idx;
  logic [width_p-1:0]  sel_data;
  logic                accept;

  assign stage_ready = ~valid_q | ready_i;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt      = owner_q;
    gnt_vld  = 1'b0;
    scan_idx = 0;
    cand     = '0;
    if (state_q == LOCKED) begin
      gnt_vld = 1'b1;
    end else begin
      for (int i = 0; i < num_req_p; i++) begin
        scan_idx = int'(ptr_q) + i;
        if (scan_idx >= num_req_p) scan_idx = scan_idx - num_req_p;
        cand = id_w_p'(scan_idx);
        if (!gnt_vld && valid_i[cand]) begin
          gnt     = cand;
          gnt_vld = 1'b1;
        end
      end
    end
  end

  // Reset gates ready_o directly so upstream never sees a handshake while held in reset.
  always_comb begin
    ready_o = '0;
    if (reset_ni && gnt_vld && stage_ready) ready_o[gnt] = 1'b1;
  end

  assign accept = valid_i[gnt] & ready_o[gnt];

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < num_req_p; k++) begin
      if (gnt == id_w_p'(k)) sel_data = data_i[k*width_p +: width_p];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    valid_d = stage_ready ? accept : valid_q;
    data_d  = data_q;
    last_d  = last_q;
    id_d    = id_q;
    if (accept) begin
      data_d = sel_data;
      last_d = last_i[gnt];
      id_d   = gnt;
      if (last_i[gnt]) begin
        state_d = IDLE;
        ptr_d   = (gnt == id_w_p'(num_req_p - 1)) ? '0 : gnt + id_w_p'(1);
      end else begin
        state_d = LOCKED;
        owner_d = gnt;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      id_q    <= id_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign id_o    = id_q;

endmodule

// File: tb/tb_elastic_rr_arbiter.sv
// Bench for elastic_rr_arbiter: per-requester packet queues as sources, a
// behavioural arbitration model, and a per-requester beat scoreboard.
module tb_elastic_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset_ni;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   valid_i, last_i, ready_o;
  logic           valid_o, last_o, ready_i;
  logic [W-1:0]   data_o;
  logic [1:0]     id_o;

  elastic_rr_arbiter #(.width_p(W), .num_req_p(N)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .data_i(data_i), .valid_i(valid_i),
    .last_i(last_i), .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o),
    .last_o(last_o), .id_o(id_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W:0]   pend[N][$];  // source beats {last, data}, head presented
  logic [W:0]   sb[N][$];    // accepted beats awaiting output, per requester
  logic [N-1:0] gap = '0;
  bit           rdy = 1'b1;

  // Behavioural model of arbitration state.
  bit m_lock;
  int m_owner, m_ptr, m_out_id;
  bit m_out_valid;

  // Sampled DUT outputs from the most recent cycle.
  logic         s_valid, s_last;
  logic [1:0]   s_id;
  logic [W-1:0] s_data;
  logic [N-1:0] s_ready;

  function automatic int grant();
    if (m_lock) return m_owner;
    for (int i = 0; i < N; i++) begin
      if (valid_i[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic clear_all();
    m_lock = 0; m_owner = 0; m_ptr = 0; m_out_valid = 0; m_out_id = 0;
    gap = '0;
    for (int k = 0; k < N; k++) begin
      pend[k].delete();
      sb[k].delete();
    end
  endtask

  // Entered one time unit after a rising edge; leaves one unit after the next.
  task automatic cycle();
    int g;
    bit sr, acc;
    logic [N-1:0] er;
    logic [W:0] h, b;
    for (int k = 0; k < N; k++) begin
      if (pend[k].size() > 0 && !gap[k]) begin
        h = pend[k][0];
        valid_i[k] = 1'b1;
        data_i[k*W +: W] = h[W-1:0];
        last_i[k] = h[W];
      end else begin
        valid_i[k] = 1'b0;
        data_i[k*W +: W] = W'($urandom);
        last_i[k] = 1'($urandom);
      end
    end
    ready_i = rdy;
    @(negedge clk);
    sr = !m_out_valid || ready_i;
    g = grant();
    er = '0;
    if (g >= 0 && sr) er[g] = 1'b1;
    checks++;
    if (ready_o !== er) begin
      errors++;
      $display("FAIL ready_o cyc=%0d got=%b exp=%b", cyc, ready_o, er);
    end
    checks++;
    if (valid_o !== m_out_valid) begin
      errors++;
      $display("FAIL valid_o cyc=%0d got=%b exp=%b", cyc, valid_o, m_out_valid);
    end
    if (m_out_valid) begin
      checks++;
      if (id_o !== 2'(m_out_id)) begin
        errors++;
        $display("FAIL id_o cyc=%0d got=%0d exp=%0d", cyc, id_o, m_out_id);
      end
    end
    if (valid_o === 1'b1 && ready_i) begin
      checks++;
      if (sb[id_o].size() == 0) begin
        errors++;
        $display("FAIL scoreboard cyc=%0d got=unexpected beat id %0d exp=none", cyc, id_o);
      end else begin
        b = sb[id_o].pop_front();
        if ({last_o, data_o} !== b) begin
          errors++;
          $display("FAIL beat cyc=%0d id=%0d got=%h exp=%h", cyc, id_o, {last_o, data_o}, b);
        end
      end
    end
    s_valid = valid_o; s_id = id_o; s_data = data_o; s_last = last_o; s_ready = ready_o;
    acc = (g >= 0) && valid_i[g] && sr;
    if (sr) m_out_valid = acc;
    if (acc) begin
      m_out_id = g;
      b = pend[g].pop_front();
      sb[g].push_back(b);
      if (b[W]) begin
        m_lock = 0;
        m_ptr = (g + 1) % N;
      end else begin
        m_lock = 1;
        m_owner = g;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    bit busy;
    gap = '0;
    rdy = 1'b1;
    do begin
      busy = m_out_valid;
      for (int k = 0; k < N; k++) if (pend[k].size() > 0) busy = 1;
      if (busy) begin
        cycle();
        n++;
      end
    end while (busy && n < 200);
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL drain_timeout got=busy after %0d cycles exp=idle", n);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (sb[k].size() != 0) begin
        errors++;
        $display("FAIL lost_beats req=%0d got=%0d pending exp=0", k, sb[k].size());
      end
    end
  endtask

  // Holds reset across one rising edge with every requester valid.
  task automatic do_reset();
    reset_ni = 1'b0;
    valid_i = '1;
    last_i = '1;
    data_i = N*W'($urandom);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ready_o !== '0 || valid_o !== 1'b0 || data_o !== '0) begin
      errors++;
      $display("FAIL reset_state got=ready %b valid %b data %h exp=0000 0 00", ready_o, valid_o, data_o);
    end
    clear_all();
    #2 reset_ni = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < N; k++) pend[k].push_back({1'b1, 8'(8'h40 + k)});
    cycle();
    checks++;
    if (s_ready !== 4'b0001) begin
      errors++;
      $display("FAIL first_grant got=%b exp=0001", s_ready);
    end
    drain();
  endtask

  task automatic test_round_robin();
    int e;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < N; k++)
        if (pend[k].size() == 0) pend[k].push_back({1'b1, 8'(8'h10 + k)});
      cycle();
      if (c >= 1) begin
        e = (c - 1) % N;
        checks++;
        if (!s_valid || s_id !== 2'(e) || s_data !== 8'(8'h10 + e)) begin
          errors++;
          $display("FAIL rr_seq step=%0d got=v%b id%0d %h exp=v1 id%0d %h", c, s_valid, s_id, s_data, e, 8'(8'h10 + e));
        end
      end
    end
    drain();
  endtask

  task automatic test_packet_lock();
    int exp_id[5] = '{2, 2, 2, 3, 0};
    do_reset();
    pend[1].push_back({1'b1, 8'h01});
    cycle();
    pend[2].push_back({1'b0, 8'h20});
    pend[2].push_back({1'b0, 8'h21});
    pend[2].push_back({1'b1, 8'h22});
    pend[0].push_back({1'b1, 8'hA0});
    pend[3].push_back({1'b1, 8'hA3});
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (c <= 2) begin
        checks++;
        if (s_ready !== 4'b0100) begin
          errors++;
          $display("FAIL lock_ready step=%0d got=%b exp=0100", c, s_ready);
        end
      end
      if (c >= 1) begin
        checks++;
        if (!s_valid || s_id !== 2'(exp_id[c-1])) begin
          errors++;
          $display("FAIL lock_seq step=%0d got=v%b id%0d exp=v1 id%0d", c, s_valid, s_id, exp_id[c-1]);
        end
      end
    end
    drain();
  endtask

  task automatic test_bubble();
    do_reset();
    pend[0].push_back({1'b1, 8'hB0});
    cycle();
    pend[1].push_back({1'b0, 8'hC0});
    pend[1].push_back({1'b0, 8'hC1});
    pend[1].push_back({1'b1, 8'hC2});
    pend[0].push_back({1'b1, 8'hB1});
    cycle();
    gap[1] = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      cycle();
      checks++;
      if (s_ready !== 4'b0010) begin
        errors++;
        $display("FAIL bubble_ready step=%0d got=%b exp=0010", c, s_ready);
      end
    end
    gap = '0;
    for (int c = 3; c <= 6; c++) begin
      cycle();
      if (c == 3) begin
        checks++;
        if (s_valid !== 1'b0) begin
          errors++;
          $display("FAIL bubble_valid step=%0d got=%b exp=0", c, s_valid);
        end
      end
      if (c == 5) begin
        checks++;
        if (!s_valid || s_id !== 2'd1 || s_last !== 1'b1 || s_data !== 8'hC2) begin
          errors++;
          $display("FAIL bubble_end got=v%b id%0d l%b %h exp=v1 id1 l1 c2", s_valid, s_id, s_last, s_data);
        end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    do_reset();
    pend[1].push_back({1'b1, 8'hA5});
    cycle();
    pend[0].push_back({1'b1, 8'h30});
    pend[2].push_back({1'b0, 8'h31});
    pend[2].push_back({1'b1, 8'h32});
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      checks++;
      if (s_ready !== '0 || !s_valid || s_data !== 8'hA5 || s_id !== 2'd1 || s_last !== 1'b1) begin
        errors++;
        $display("FAIL backpressure step=%0d got=r%b v%b %h id%0d l%b exp=r0000 v1 a5 id1 l1", c, s_ready, s_valid, s_data, s_id, s_last);
      end
    end
    drain();
  endtask

  task automatic test_async_reset();
    do_reset();
    pend[3].push_back({1'b0, 8'hD0});
    pend[3].push_back({1'b0, 8'hD1});
    pend[3].push_back({1'b0, 8'hD2});
    pend[3].push_back({1'b1, 8'hD3});
    cycle();
    pend[0].push_back({1'b1, 8'hE0});
    cycle();
    #1 reset_ni = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== '0 || data_o !== '0 || id_o !== '0 || last_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got=v%b r%b %h id%0d l%b exp=v0 r0000 00 id0 l0", valid_o, ready_o, data_o, id_o, last_o);
    end
    clear_all();
    pend[0].push_back({1'b1, 8'hE0});
    pend[3].push_back({1'b1, 8'hE3});
    #1 reset_ni = 1'b1;
    cycle();
    checks++;
    if (s_ready !== 4'b0001) begin
      errors++;
      $display("FAIL restart_grant got=%b exp=0001", s_ready);
    end
    drain();
  endtask

  task automatic test_random();
    int len;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        if (pend[k].size() == 0 && $urandom_range(0, 3) == 0) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) pend[k].push_back({b == len - 1, 8'($urandom)});
        end
        gap[k] = ($urandom_range(0, 4) == 0);
      end
      rdy = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();
  endtask

  initial begin
    reset_ni = 1'b0;
    valid_i = '0;
    last_i = '0;
    data_i = '0;
    ready_i = 1'b1;
    clear_all();
    @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_bubble();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
